vdp_clock_phase_gen: RTL and testbench

VDP_CLOCK_PHASE_GEN -- requirements
Module: vdp_clock_phase_gen

---
 rtl/vdp_clock_pkg.sv | 24 ++
 rtl/vdp_sync_edge.sv | 23 ++
 rtl/vdp_clock_phase_gen.sv | 143 ++++++++++++++
 tb/tb_vdp_clock_phase_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_clock_pkg.sv
// Shared constants, lock-state type and enable decode tables for the VDP
// clock phase generator.
package vdp_clock_pkg;

    localparam int PHASE_PERIOD = 24;
    localparam int PHASE_W      = 5;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_PERIOD - 1);

    // One bit per phase value; a set bit means the enable fires at that phase.
    localparam logic [PHASE_PERIOD-1:0] EN_21M_PHASES  = 24'h888888; // 3,7,11,15,19,23
    localparam logic [PHASE_PERIOD-1:0] EN_10M_PHASES  = 24'h808080; // 7,15,23
    localparam logic [PHASE_PERIOD-1:0] EN_3M58_PHASES = 24'h800000; // 23

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    function automatic logic phase_hit(input logic [PHASE_PERIOD-1:0] mask,
                                       input logic [PHASE_W-1:0]      ph);
        return (int'(ph) < PHASE_PERIOD) ? mask[ph] : 1'b0;
    endfunction

endpackage

// File: rtl/vdp_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for a slow
// asynchronous clock; rise_pulse lands 3 clk edges after the input rises.
module vdp_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_async,
    output logic rise_pulse
);

    // [0],[1] resolve metastability, [2] holds the previous synchronized level
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], d_async};
            rise_pulse <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/vdp_clock_phase_gen.sv
// 24-phase VDP clock sequencer locked to the MSX bus clock, with decoded
// clock enables and a stretched downstream reset.
module vdp_clock_phase_gen
    import vdp_clock_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 1024,
    parameter int unsigned ALIGN_PHASE    = 0,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ext_clk,
    output logic [PHASE_W-1:0] phase,
    output logic               enable_21m,
    output logic               enable_10m,
    output logic               enable_3m58,
    output logic               locked,
    output logic               reset_n_out
);

    localparam int STR_W   = $clog2(STRETCH_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [PHASE_W-1:0] ALIGN_VAL    = PHASE_W'(ALIGN_PHASE);
    localparam logic [PHASE_W-1:0] IN_PHASE_VAL =
        PHASE_W'((ALIGN_PHASE + PHASE_PERIOD - 1) % PHASE_PERIOD);
    localparam logic [STR_W-1:0]   STR_MAX      = STR_W'(STRETCH_CYCLES);
    localparam logic [TO_W-1:0]    TO_MAX       = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]    TO_HIT       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST   = MATCH_W'(LOCK_COUNT - 1);

    logic               edge_pulse;
    logic               in_phase;
    logic               realign;
    lock_state_e        state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               miss_q, miss_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [PHASE_W-1:0] phase_d;
    logic [STR_W-1:0]   rst_cnt_q, rst_cnt_d;

    vdp_sync_edge u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_async    (ext_clk),
        .rise_pulse (edge_pulse)
    );

    assign in_phase = edge_pulse && (phase == IN_PHASE_VAL);

    // to_q lags the cycles-since-edge count by one, so the compare on to_d
    // drops lock exactly TIMEOUT_CYCLES cycles after the last edge_pulse.
    assign to_d = edge_pulse ? '0 : ((to_q == TO_MAX) ? to_q : to_q + TO_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_UNLOCKED;
            match_q <= '0;
            miss_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        realign = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (edge_pulse) begin
                    realign = 1'b1;
                    match_d = in_phase ? match_q + MATCH_W'(1) : '0;
                    if (in_phase && match_q == MATCH_LAST) begin
                        state_d = ST_LOCKED;
                        miss_d  = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_pulse) begin
                    if (in_phase) begin
                        miss_d = 1'b0;
                    end else if (!miss_q) begin
                        miss_d = 1'b1;
                    end else begin
                        state_d = ST_UNLOCKED;
                        match_d = '0;
                        miss_d  = 1'b0;
                        realign = 1'b1;
                    end
                end else if (to_d == TO_HIT) begin
                    state_d = ST_UNLOCKED;
                    match_d = '0;
                    miss_d  = 1'b0;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Realign wins over the natural wrap; enables decode the value being loaded.
    assign phase_d = realign ? ALIGN_VAL :
                     ((phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= '0;
            enable_21m  <= 1'b0;
            enable_10m  <= 1'b0;
            enable_3m58 <= 1'b0;
        end else begin
            phase       <= phase_d;
            enable_21m  <= phase_hit(EN_21M_PHASES, phase_d);
            enable_10m  <= phase_hit(EN_10M_PHASES, phase_d);
            enable_3m58 <= phase_hit(EN_3M58_PHASES, phase_d);
        end
    end

    assign rst_cnt_d = (rst_cnt_q == STR_MAX) ? rst_cnt_q : rst_cnt_q + STR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt_q   <= '0;
            reset_n_out <= 1'b0;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            reset_n_out <= (rst_cnt_d == STR_MAX);
        end
    end

endmodule

// File: tb/tb_vdp_clock_phase_gen.sv
// Directed scenario bench for vdp_clock_phase_gen with a per-cycle
// expectation scoreboard of {phase, enables, locked, reset_n_out}.
module tb_vdp_clock_phase_gen;

    localparam int STRETCH = 1024;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ext_clk = 1'b0;
    logic [4:0] phase;
    logic       enable_21m, enable_10m, enable_3m58, locked, reset_n_out;

    int         checks = 0;
    int         errors = 0;
    int         rel_cnt = 0;
    logic [4:0] exp_ph = 5'd0;
    logic [9:0] sb_q[$];
    logic [9:0] obs;

    assign obs = {phase, enable_21m, enable_10m, enable_3m58, locked, reset_n_out};

    vdp_clock_phase_gen #(
        .STRETCH_CYCLES (STRETCH),
        .ALIGN_PHASE    (0),
        .LOCK_COUNT     (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ext_clk     (ext_clk),
        .phase       (phase),
        .enable_21m  (enable_21m),
        .enable_10m  (enable_10m),
        .enable_3m58 (enable_3m58),
        .locked      (locked),
        .reset_n_out (reset_n_out)
    );

    always #5 clk = ~clk;

    // Pushes what the outputs must show after the coming edge, then clocks it.
    task automatic drive(input logic ext, input logic realign, input logic exp_lock);
        logic [4:0] p;
        rel_cnt++;
        p = realign ? 5'd0 : ((exp_ph == 5'd23) ? 5'd0 : exp_ph + 5'd1);
        exp_ph = p;
        sb_q.push_back({p, p inside {5'd3, 5'd7, 5'd11, 5'd15, 5'd19, 5'd23},
                        p inside {5'd7, 5'd15, 5'd23}, p == 5'd23,
                        exp_lock, rel_cnt >= STRETCH});
        ext_clk = ext;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] e;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 10'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rel_cnt = 0;
        exp_ph  = 5'd0;
        for (int i = 0; i < STRETCH + 6; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL stretch i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_free_run;
        logic [9:0] e;
        int n21 = 0, n10 = 0, n3 = 0;
        for (int i = 0; i < 72; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL free_run i=%0d: got %b expected %b", i, obs, e);
            end
            n21 += int'(enable_21m);
            n10 += int'(enable_10m);
            n3  += int'(enable_3m58);
        end
        checks++;
        if (n21 != 18 || n10 != 9 || n3 != 3) begin
            errors++;
            $display("FAIL free_run_counts: got %0d/%0d/%0d expected 18/9/3", n21, n10, n3);
        end
    endtask

    task automatic test_lock;
        logic [9:0] e;
        int n = $urandom_range(0, 23);
        // Arbitrary offset, but the first edge must land out of phase.
        for (int i = 0; i < n || exp_ph == 5'd20; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lock_idle i=%0d: got %b expected %b", i, obs, e);
            end
        end
        for (int i = 0; i < 120; i++) begin
            drive((i % 24) < 12, i == 3, i >= 99);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lock i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_glitch;
        logic [9:0] e;
        for (int i = 0; i < 96; i++) begin
            int k   = i / 24;
            int off = i % 24;
            int r   = (k == 1) ? 5 : 0;
            drive(off >= r && off < r + 12, 1'b0, 1'b1);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL glitch i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_double_miss;
        logic [9:0] e;
        for (int i = 0; i < 192; i++) begin
            int k   = i / 24;
            int off = i % 24;
            int r   = (k == 1 || k == 2) ? 5 : 0;
            drive(off >= r && off < r + 12, i == 56 || i == 75, i < 56 || i >= 171);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL double_miss i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [9:0] e;
        // Last edge_pulse follows the edge of call 2; lock must go 64 later.
        for (int i = 0; i < 100; i++) begin
            drive(i < 12, 1'b0, i < 2 + TIMEOUT);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [9:0] e;
        reset_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rel_cnt = 0;
        exp_ph  = 5'd0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midrun_pre i=%0d: got %b expected %b", i, obs, e);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("FAIL midrun_clear: got %b expected %b", obs, 10'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rel_cnt = 0;
        exp_ph  = 5'd0;
        for (int i = 0; i < STRETCH + 4; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midrun_stretch i=%0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_lock();
        test_glitch();
        test_double_miss();
        test_timeout();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
